residual_binarizer: RTL and testbench

Stage directly downstream of the PopCount block in the ReBNet datapath. It accumulates `FOLD` signed popcount results belonging to one output neuron, then applies residual binarization over `WEIGHT_LEVELS` scaling factors, one level per cycle. It emits a `WEIGHT_LEVELS`-bit activation code that feeds the next layer's PopCount `in` bus.

---
 rtl/residual_binarizer_pkg.sv | 27 ++
 rtl/residual_binarizer_if.sv | 37 +++
 rtl/residual_binarizer_level_step.sv | 21 ++
 rtl/residual_binarizer.sv | 136 +++++++++++++
 tb/tb_residual_binarizer.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/residual_binarizer_pkg.sv
// Shared types and width helpers for the residual binarizer stage.
// Optional bias support is selected elsewhere with RESBIN_BIAS_EN.
package resbin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    BIN
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

  // One extra bit over the popcount width per doubling of the fold, plus one for the bias.
  function automatic int unsigned acc_width(input int unsigned pop_width, input int unsigned fold);
    return pop_width + clog2(fold) + 1;
  endfunction

  function automatic int unsigned res_width(input int unsigned pop_width, input int unsigned fold);
    return acc_width(pop_width, fold) + 2;
  endfunction

endpackage

// File: rtl/residual_binarizer_if.sv
// Handshake and data bundle between PopCount, the binarizer and the next layer.
// The bias field exists only when RESBIN_BIAS_EN is defined.
interface residual_binarizer_if #(
  parameter int unsigned WEIGHT_LEVELS  = 2,
  parameter int unsigned POPCOUNT_WIDTH = 8
);
  logic                                    in_valid;
  logic                                    in_ready;
  logic [POPCOUNT_WIDTH-1:0]               in_data;
  logic [WEIGHT_LEVELS*POPCOUNT_WIDTH-1:0] gamma;
`ifdef RESBIN_BIAS_EN
  logic [POPCOUNT_WIDTH-1:0]               bias;
`endif
  logic [WEIGHT_LEVELS-1:0]                out_bits;
  logic                                    out_valid;

`ifdef RESBIN_BIAS_EN
  modport master (
    output in_valid, in_data, gamma, bias,
    input  in_ready, out_bits, out_valid
  );
  modport slave (
    input  in_valid, in_data, gamma, bias,
    output in_ready, out_bits, out_valid
  );
`else
  modport master (
    output in_valid, in_data, gamma,
    input  in_ready, out_bits, out_valid
  );
  modport slave (
    input  in_valid, in_data, gamma,
    output in_ready, out_bits, out_valid
  );
`endif

endinterface

// File: rtl/residual_binarizer_level_step.sv
// One residual binarization level: sign of the residual, then step it by gamma.
// Unaffected by RESBIN_BIAS_EN.
module resbin_level_step #(
  parameter int unsigned RES_WIDTH   = 12,
  parameter int unsigned GAMMA_WIDTH = 8
) (
  input  logic signed [RES_WIDTH-1:0]   res,
  input  logic        [GAMMA_WIDTH-1:0] gamma,
  output logic                          level_bit,
  output logic signed [RES_WIDTH-1:0]   res_next
);

  logic signed [RES_WIDTH-1:0] gamma_ext;

  assign gamma_ext = {{(RES_WIDTH-GAMMA_WIDTH){1'b0}}, gamma};

  // A residual of exactly zero counts as positive.
  assign level_bit = ~res[RES_WIDTH-1];
  assign res_next  = level_bit ? (res - gamma_ext) : (res + gamma_ext);

endmodule

// File: rtl/residual_binarizer.sv
// Accumulates FOLD popcounts per neuron, then emits a WEIGHT_LEVELS-bit residual code.
// Define RESBIN_BIAS_EN to add the signed bias on the final fold.
module residual_binarizer
  import resbin_pkg::*;
#(
  parameter int unsigned WEIGHT_LEVELS  = 2,
  parameter int unsigned POPCOUNT_WIDTH = 8,
  parameter int unsigned FOLD           = 4
) (
  input logic                  clk,
  input logic                  rst,
  residual_binarizer_if.slave  bus
);

  localparam int unsigned PW = POPCOUNT_WIDTH;
  localparam int unsigned WL = WEIGHT_LEVELS;
  localparam int unsigned AW = acc_width(POPCOUNT_WIDTH, FOLD);
  localparam int unsigned RW = res_width(POPCOUNT_WIDTH, FOLD);
  localparam int unsigned CW = clog2(FOLD) + 1;
  localparam int unsigned KW = (WEIGHT_LEVELS > 1) ? clog2(WEIGHT_LEVELS) : 1;

  state_t               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] data_ext, addend;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [RW-1:0] res_q, res_d;
  logic signed [RW-1:0] step_res, step_next;
  logic                 step_bit;
  logic [PW-1:0]        gamma_k;
  logic [WL-1:0]        level_mask;
  logic [WL-1:0]        bits_q, bits_d;
  logic [WL-1:0]        out_bits_q, out_bits_d;
  logic                 out_valid_q, out_valid_d;
  logic                 ready;
  logic                 last_fold;

  assign ready     = (state_q != BIN);
  assign last_fold = ((state_q == IDLE) && (FOLD == 1)) ||
                     ((state_q == ACC) && (cnt_q == CW'(FOLD - 1)));
  assign data_ext  = {{(AW-PW){bus.in_data[PW-1]}}, bus.in_data};

`ifdef RESBIN_BIAS_EN
  logic signed [AW-1:0] bias_ext;
  assign bias_ext = {{(AW-PW){bus.bias[PW-1]}}, bus.bias};
  assign addend   = last_fold ? (data_ext + bias_ext) : data_ext;
`else
  assign addend   = data_ext;
`endif

  // The first level reads the accumulator directly, so no extra load cycle is spent entering BIN.
  assign step_res   = (k_q == '0) ? {{2{acc_q[AW-1]}}, acc_q} : res_q;
  assign gamma_k    = PW'(bus.gamma >> (k_q * PW));
  assign level_mask = WL'(1) << k_q;

  resbin_level_step #(
    .RES_WIDTH  (RW),
    .GAMMA_WIDTH(PW)
  ) u_level_step (
    .res      (step_res),
    .gamma    (gamma_k),
    .level_bit(step_bit),
    .res_next (step_next)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    res_d       = res_q;
    bits_d      = bits_q;
    out_bits_d  = out_bits_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d = addend;
          cnt_d = CW'(1);
          k_d   = '0;
          state_d = (FOLD == 1) ? BIN : ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_d = acc_q + addend;
          cnt_d = cnt_q + 1'b1;
          if (last_fold) begin
            state_d = BIN;
            k_d     = '0;
          end
        end
      end
      BIN: begin
        res_d  = step_next;
        bits_d = step_bit ? (bits_q | level_mask) : (bits_q & ~level_mask);
        if (k_q == KW'(WEIGHT_LEVELS - 1)) begin
          out_bits_d  = bits_d;
          out_valid_d = 1'b1;
          k_d         = '0;
          state_d     = IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      res_q       <= '0;
      bits_q      <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      res_q       <= res_d;
      bits_q      <= bits_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_bits  = out_bits_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_residual_binarizer.sv
// Directed bench for residual_binarizer with FOLD=2, gamma0=8, gamma1=4.
// The bias scenario runs only when RESBIN_BIAS_EN is defined.
module tb_residual_binarizer;
  import resbin_pkg::*;

  localparam int unsigned WL   = 2;
  localparam int unsigned PW   = 8;
  localparam int unsigned FOLD = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  residual_binarizer_if #(.WEIGHT_LEVELS(WL), .POPCOUNT_WIDTH(PW)) bus ();

  residual_binarizer #(
    .WEIGHT_LEVELS (WL),
    .POPCOUNT_WIDTH(PW),
    .FOLD          (FOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives two back-to-back inputs; returns at the negedge after the second is sampled.
  task automatic feed_pair(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    @(negedge clk);
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic run_neuron(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] exp_bits);
    feed_pair(a, b);
    check({tag, "_ready_bin"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_valid_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid_pulse"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_bits"}, 32'(bus.out_bits), 32'(exp_bits));
    check({tag, "_ready_pulse"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check({tag, "_valid_end"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_bits_hold"}, 32'(bus.out_bits), 32'(exp_bits));
  endtask

  logic [7:0] stream_data [10];
  logic       stream_valid_exp [10];
  int         pulses;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.gamma    = {8'd4, 8'd8};
`ifdef RESBIN_BIAS_EN
    bus.bias     = 8'h00;
`endif
    repeat (2) @(negedge clk);
    check("rst_out_bits", 32'(bus.out_bits), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_acc", 32'(dut.acc_q), 32'd0);
    check("rst_cnt", 32'(dut.cnt_q), 32'd0);
    check("rst_k", 32'(dut.k_q), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_neuron("pos_15", 8'd10, 8'd5, 2'b11);
    run_neuron("neg_13", 8'hF6, 8'hFD, 2'b00);
    run_neuron("zero", 8'd3, 8'hFD, 2'b01);
`ifdef RESBIN_BIAS_EN
    bus.bias = 8'hEC;
    run_neuron("bias_m20", 8'd10, 8'd5, 2'b10);
    bus.bias = 8'h00;
`endif
    run_neuron("pre_abort", 8'd10, 8'd5, 2'b11);

    // Reset one cycle into BIN must abort the neuron and clear the held code.
    feed_pair(8'd10, 8'd5);
    check("abort_in_bin", 32'(dut.state_q), 32'(BIN));
    rst = 1'b0;
    #1;
    check("abort_bits_clr", 32'(bus.out_bits), 32'd0);
    check("abort_acc_clr", 32'(dut.acc_q), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    check("abort_bits_zero", 32'(bus.out_bits), 32'd0);
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    run_neuron("post_abort", 8'd10, 8'd5, 2'b11);

    // in_valid high for six cycles: samples 2 and 3 land in BIN and must be dropped.
    stream_data = '{8'd10, 8'd5, 8'd100, 8'd100, 8'hF6, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00};
    stream_valid_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stream_valid_%0d", i), 32'(bus.out_valid), 32'(stream_valid_exp[i]));
      if (bus.out_valid === 1'b1) pulses++;
      if (i == 4) check("stream_bits_n0", 32'(bus.out_bits), 32'd3);
      if (i == 8) check("stream_bits_n1", 32'(bus.out_bits), 32'd0);
      bus.in_valid = (i < 6);
      bus.in_data  = stream_data[i];
    end
    check("stream_pulses", 32'(pulses), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
